// File: rtl/add_tc_sched.sv
// add_tc_sched
// Round-robin scheduler that shares one 32-bit two's-complement adder among
// NREQ requesters. The grant is combinational, the sum is registered into a
// single-entry output stage, and that stage is tagged with the requester ID
// and a signed-overflow flag.
//
// Parameters
//   NREQ  number of requesters (2..16)
//   IDW   result ID width, derived from NREQ (not meant to be overridden)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  per-requester valid
//   req_ready  one-hot grant (all zero when the output stage cannot accept)
//   req_a      packed signed operand A, lane i at [32*i+31:32*i]
//   req_b      packed signed operand B, same packing
//   res_valid  output stage holds a result
//   res_ready  consumer accepts the result
//   res_data   signed sum (saturated when ADD_TC_SAT_EN is defined)
//   res_id     index of the requester that produced res_data
//   res_ovf    signed overflow on this add
//   op_cnt     count of accepted requests, wraps at 2^32
//
// Build option
//   ADD_TC_SAT_EN  when defined, res_data clamps to the signed extremes on
//                  overflow; otherwise it is the wrapped sum. res_ovf is
//                  reported either way.
module add_tc_sched #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*32-1:0]     req_a,
    input  logic [NREQ*32-1:0]     req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic signed [31:0]     res_data,
    output logic [IDW-1:0]         res_id,
    output logic                   res_ovf,
    output logic [31:0]            op_cnt
);

    localparam int DATA_W = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                    state;
    logic [IDW-1:0]            ptr;

    logic signed [DATA_W-1:0]  a_arr [NREQ];
    logic signed [DATA_W-1:0]  b_arr [NREQ];

    logic                      found;
    logic [IDW-1:0]            gnt_idx;
    logic [NREQ-1:0]           gnt_oh;
    logic [IDW-1:0]            cand;
    int                        cand_i;
    logic                      acc;
    logic                      xfer;

    logic signed [DATA_W-1:0]  a_p0;
    logic signed [DATA_W-1:0]  b_p0;
    logic signed [DATA_W-1:0]  sum_p0;
    logic signed [DATA_W-1:0]  data_p0;
    logic                      ovf_p0;

    // Signed overflow: operands agree in sign but the wrapped sum does not.
    function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b,
                                     input logic signed [DATA_W-1:0] s);
        return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    endfunction

`ifdef ADD_TC_SAT_EN
    // Clamp toward the sign of operand A; on overflow both operands share it.
    function automatic logic signed [DATA_W-1:0] sat_s(input logic signed [DATA_W-1:0] wrap,
                                                       input logic                     ovf,
                                                       input logic                     neg);
        if (!ovf)
            return wrap;
        else if (neg)
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return {1'b0, {(DATA_W-1){1'b1}}};
    endfunction
`endif

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = req_a[i*DATA_W +: DATA_W];
            b_arr[i] = req_b[i*DATA_W +: DATA_W];
        end
    end

    // Rotating priority search starting just after the last granted index.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        cand_i  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_i = int'(ptr) + k;
            if (cand_i >= NREQ)
                cand_i = cand_i - NREQ;
            cand = cand_i[IDW-1:0];
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_oh = found ? (NREQ'(1) << gnt_idx) : '0;
    end

    // The output stage can take new data when empty or when it is being drained
    // this cycle; this is the res_ready -> req_ready combinational path.
    assign acc       = (state == EMPTY) || res_ready;
    assign xfer      = found && acc && !rst;
    assign req_ready = xfer ? gnt_oh : '0;

    // Stage 0: operand select and add for the granted requester.
    always_comb begin
        a_p0   = a_arr[gnt_idx];
        b_p0   = b_arr[gnt_idx];
        sum_p0 = a_p0 + b_p0;
        ovf_p0 = add_ovf(a_p0, b_p0, sum_p0);
`ifdef ADD_TC_SAT_EN
        data_p0 = sat_s(sum_p0, ovf_p0, a_p0[DATA_W-1]);
`else
        data_p0 = sum_p0;
`endif
    end

    // Stage 1: registered output and control FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_ovf   <= 1'b0;
            op_cnt    <= '0;
            ptr       <= IDW'(NREQ - 1);
        end else begin
            if (xfer) begin
                res_data <= data_p0;
                res_id   <= gnt_idx;
                res_ovf  <= ovf_p0;
                ptr      <= gnt_idx;
                op_cnt   <= op_cnt + 32'd1;
            end
            case (state)
                EMPTY: begin
                    if (xfer) begin
                        state     <= FULL;
                        res_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (res_ready && !xfer) begin
                        state     <= EMPTY;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_tc_sched.sv
// Testbench for add_tc_sched (NREQ = 4). Table-driven single-transfer
// vectors followed by hand-written stall, reset, round-robin and counter
// wrap sequences. Build with +define+ADD_TC_SAT_EN to check the saturating
// variant.
module tb_add_tc_sched;

    localparam int NREQ = 4;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic               res_valid;
    logic               res_ready;
    logic signed [31:0] res_data;
    logic [1:0]         res_id;
    logic               res_ovf;
    logic [31:0]        op_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt;

    add_tc_sched #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf),
        .op_cnt    (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp_rdy;
        logic        exp_vld;
        logic [31:0] exp_wrap;
        logic [31:0] exp_sat;
        logic [1:0]  exp_id;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = a;
            req_b[32*i +: 32] = b;
        end
    endtask

    function automatic logic [31:0] pick(input logic [31:0] wrap, input logic [31:0] sat);
`ifdef ADD_TC_SAT_EN
        return sat;
`else
        return wrap;
`endif
    endfunction

    initial begin
        // vld, a, b, exp_rdy, exp_vld, wrapped sum, saturated sum, id, ovf
        tbl[0] = '{4'b0001, 32'd5,        32'hFFFF_FFFD, 4'b0001, 1'b1, 32'd2,         32'd2,         2'd0, 1'b0};
        tbl[1] = '{4'b0100, 32'd100,      32'hFFFF_FF06, 4'b0100, 1'b1, 32'hFFFF_FF6A, 32'hFFFF_FF6A, 2'd2, 1'b0};
        tbl[2] = '{4'b1000, 32'h7FFF_FFFF, 32'd1,        4'b1000, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 2'd3, 1'b1};
        tbl[3] = '{4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 1'b1};
        tbl[4] = '{4'b1111, 32'hFFFF_FFF8, 32'hFFFF_FFF7, 4'b0100, 1'b1, 32'hFFFF_FFEF, 32'hFFFF_FFEF, 2'd2, 1'b0};
        tbl[5] = '{4'b1011, 32'h8000_0000, 32'h8000_0000, 4'b1000, 1'b1, 32'h0000_0000, 32'h8000_0000, 2'd3, 1'b1};
        tbl[6] = '{4'b0110, 32'h7FFF_FFFF, 32'h8000_0000, 4'b0010, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1, 1'b0};
        tbl[7] = '{4'b0000, 32'd0,        32'd0,         4'b0000, 1'b0, 32'd0,         32'd0,         2'd0, 1'b0};
        tbl[8] = '{4'b1001, 32'h4000_0000, 32'h4000_0000, 4'b1000, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 2'd3, 1'b1};
        tbl[9] = '{4'b0001, 32'd0,        32'd0,         4'b0001, 1'b1, 32'd0,         32'd0,         2'd0, 1'b0};

        rst       = 1'b1;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        exp_cnt   = 32'd0;

        // Reset state, with requests pending so the grant gating is visible.
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_res_data",  res_data,       32'h0);
        chk("rst_res_id",    32'(res_id),    32'h0);
        chk("rst_res_ovf",   32'(res_ovf),   32'h0);
        chk("rst_op_cnt",    op_cnt,         32'h0);

        req_valid = '0;
        rst       = 1'b0;
        #1;

        // Table-driven single transfers; grant order depends on the RR pointer.
        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].vld;
            set_ops(tbl[i].a, tbl[i].b);
            #1;
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].exp_rdy));
            if (tbl[i].exp_rdy != 4'b0000)
                exp_cnt = exp_cnt + 32'd1;
            tick();
            chk($sformatf("v%0d_res_valid", i), 32'(res_valid), 32'(tbl[i].exp_vld));
            if (tbl[i].exp_vld) begin
                chk($sformatf("v%0d_res_data", i), res_data, pick(tbl[i].exp_wrap, tbl[i].exp_sat));
                chk($sformatf("v%0d_res_id", i),   32'(res_id),  32'(tbl[i].exp_id));
                chk($sformatf("v%0d_res_ovf", i),  32'(res_ovf), 32'(tbl[i].exp_ovf));
            end
            chk($sformatf("v%0d_op_cnt", i), op_cnt, exp_cnt);
        end

        // Backpressure: result held with res_ready low, requester 1 waiting.
        req_valid = 4'b0100;
        set_ops(32'd123, 32'd4);
        tick();
        chk("stall_load_data", res_data, 32'd127);
        req_valid = 4'b0010;
        res_ready = 1'b0;
        set_ops(32'd1000, 32'd1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_req_ready", c), 32'(req_ready), 32'h0);
            tick();
            chk($sformatf("stall%0d_res_valid", c), 32'(res_valid), 32'h1);
            chk($sformatf("stall%0d_res_data", c),  res_data,       32'd127);
            chk($sformatf("stall%0d_res_id", c),    32'(res_id),    32'd2);
            chk($sformatf("stall%0d_res_ovf", c),   32'(res_ovf),   32'd0);
        end
        res_ready = 1'b1;
        #1;
        chk("unstall_req_ready", 32'(req_ready), 32'b0010);
        tick();
        chk("unstall_res_data", res_data,    32'd1001);
        chk("unstall_res_id",   32'(res_id), 32'd1);
        chk("unstall_op_cnt",   op_cnt,      32'd11);

        // Asynchronous reset mid-operation with a held result and pending requests.
        res_ready = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = 32'(10 * i + 1);
            req_b[32*i +: 32] = 32'd2;
        end
        #1;
        rst = 1'b1;
        #1;
        chk("arst_res_valid", 32'(res_valid), 32'h0);
        chk("arst_op_cnt",    op_cnt,         32'h0);
        chk("arst_res_data",  res_data,       32'h0);
        chk("arst_req_ready", 32'(req_ready), 32'h0);
        #1;
        rst       = 1'b0;
        res_ready = 1'b1;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b0001);

        // All four held valid: grants rotate 0,1,2,3,0 with no bubbles.
        for (int c = 0; c < 5; c++) begin
            automatic int g = c % NREQ;
            if (c > 0) begin
                #1;
                chk($sformatf("rr%0d_req_ready", c), 32'(req_ready), 32'(4'b0001 << g));
            end
            tick();
            chk($sformatf("rr%0d_res_valid", c), 32'(res_valid), 32'h1);
            chk($sformatf("rr%0d_res_id", c),    32'(res_id),    32'(g));
            chk($sformatf("rr%0d_res_data", c),  res_data,       32'(10 * g + 3));
        end
        chk("rr_op_cnt", op_cnt, 32'd5);

        // Counter wrap from 0xFFFFFFFF on one more transfer.
        req_valid = '0;
        tick();
        force dut.op_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.op_cnt;
        #1;
        chk("wrap_preload", op_cnt, 32'hFFFF_FFFF);
        req_valid = 4'b0001;
        set_ops(32'd7, 32'd8);
        tick();
        chk("wrap_op_cnt",    op_cnt,         32'h0);
        chk("wrap_res_valid", 32'(res_valid), 32'h1);
        chk("wrap_res_data",  res_data,       32'd15);

        req_valid = '0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
